// File: rtl/nouveau_busmaster.sv
// Single-word request/acknowledge to 68000-style strobe sequencer for the SDRAM controller CPU port.
// Reads complete on VALID, writes on WTERM, with a bounded wait and a strobe-high recovery gap.
module nouveau_busmaster #(
    parameter int TIMEOUT  = 255,
    parameter int RECOVERY = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        WE,
    input  logic [22:0] ADDR,
    input  logic [1:0]  BE,
    input  logic [15:0] WDATA,
    input  logic [15:0] D,
    input  logic        VALID,
    input  logic        WTERM,
    output logic [22:0] A,
    output logic        RW,
    output logic        ACCESS,
    output logic        UDS,
    output logic        LDS,
    output logic [15:0] DOUT,
    output logic        DOE,
    output logic        BUSY,
    output logic        ACK,
    output logic        ERR,
    output logic [15:0] RDATA
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int RCV_W = (RECOVERY > 1) ? $clog2(RECOVERY) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ASSERT, S_DSTROBE, S_WAIT, S_RELEASE, S_RECOVER
    } state_t;

    state_t             state_q, state_d;
    logic [22:0]        addr_q, addr_d, a_q, a_d;
    logic               we_q, we_d, rw_q, rw_d;
    logic [1:0]         be_q, be_d;
    logic [15:0]        wdata_q, wdata_d, dout_q, dout_d, rdata_q, rdata_d, d_r_q, d_r_d;
    logic               access_q, access_d, uds_q, uds_d, lds_q, lds_d;
    logic               doe_q, doe_d, ack_q, ack_d, err_q, err_d;
    logic               valid_r_q, valid_r_d, wterm_r_q, wterm_r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RCV_W-1:0]   rcv_q, rcv_d;
    logic               wait_done;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        a_d       = a_q;
        rw_d      = rw_q;
        access_d  = access_q;
        uds_d     = uds_q;
        lds_d     = lds_q;
        dout_d    = dout_q;
        doe_d     = doe_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        rcv_d     = rcv_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        wait_done = 1'b0;
        valid_r_d = VALID;
        wterm_r_d = WTERM;
        d_r_d     = D;

        case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    addr_d  = ADDR;
                    we_d    = WE;
                    be_d    = BE;
                    wdata_d = WDATA;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                // An empty byte-enable mask is rejected without touching the bus.
                if (be_q == 2'b00) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    a_d     = addr_q;
                    rw_d    = ~we_q;
                    state_d = S_ASSERT;
                end
            end
            S_ASSERT: begin
                access_d = 1'b0;
                cnt_d    = '0;
                if (we_q) begin
                    dout_d  = wdata_q;
                    doe_d   = 1'b1;
                    state_d = S_DSTROBE;
                end else begin
                    uds_d   = ~be_q[1];
                    lds_d   = ~be_q[0];
                    state_d = S_WAIT;
                end
            end
            S_DSTROBE: begin
                uds_d   = ~be_q[1];
                lds_d   = ~be_q[0];
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A response landing on the final wait cycle still wins over the timeout.
                cnt_d = cnt_q + CNT_W'(1);
                if (!we_q && !valid_r_q) begin
                    rdata_d   = d_r_q;
                    wait_done = 1'b1;
                end else if (we_q && !wterm_r_q) begin
                    wait_done = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d     = 1'b1;
                    wait_done = 1'b1;
                end
                if (wait_done) begin
                    access_d = 1'b1;
                    uds_d    = 1'b1;
                    lds_d    = 1'b1;
                    doe_d    = 1'b0;
                    ack_d    = 1'b1;
                    state_d  = S_RELEASE;
                end
            end
            S_RELEASE: begin
                rcv_d   = '0;
                state_d = (RECOVERY > 1) ? S_RECOVER : S_IDLE;
            end
            S_RECOVER: begin
                rcv_d = rcv_q + RCV_W'(1);
                if (int'(rcv_q) >= RECOVERY - 2) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            a_q       <= '0;
            rw_q      <= 1'b1;
            access_q  <= 1'b1;
            uds_q     <= 1'b1;
            lds_q     <= 1'b1;
            dout_q    <= '0;
            doe_q     <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            rcv_q     <= '0;
            valid_r_q <= 1'b1;
            wterm_r_q <= 1'b1;
            d_r_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            a_q       <= a_d;
            rw_q      <= rw_d;
            access_q  <= access_d;
            uds_q     <= uds_d;
            lds_q     <= lds_d;
            dout_q    <= dout_d;
            doe_q     <= doe_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            rcv_q     <= rcv_d;
            valid_r_q <= valid_r_d;
            wterm_r_q <= wterm_r_d;
            d_r_q     <= d_r_d;
        end
    end

    assign A      = a_q;
    assign RW     = rw_q;
    assign ACCESS = access_q;
    assign UDS    = uds_q;
    assign LDS    = lds_q;
    assign DOUT   = dout_q;
    assign DOE    = doe_q;
    assign BUSY   = (state_q != S_IDLE);
    assign ACK    = ack_q;
    assign ERR    = err_q;
    assign RDATA  = rdata_q;

endmodule

// File: tb/tb_nouveau_busmaster.sv
// Bench for nouveau_busmaster: directed and randomized transactions checked cycle by cycle
// against a transaction-level timing model (edge numbers counted from the accepting edge).
module tb_nouveau_busmaster;

    localparam int TIMEOUT  = 8;
    localparam int RECOVERY = 2;

    logic        CLK = 1'b0;
    logic        RST, REQ, WE, VALID, WTERM;
    logic [22:0] ADDR;
    logic [1:0]  BE;
    logic [15:0] WDATA, D;
    logic [22:0] A;
    logic        RW, ACCESS, UDS, LDS, DOE, BUSY, ACK, ERR;
    logic [15:0] DOUT, RDATA;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] model_rdata;

    nouveau_busmaster #(.TIMEOUT(TIMEOUT), .RECOVERY(RECOVERY)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .ADDR(ADDR), .BE(BE),
        .WDATA(WDATA), .D(D), .VALID(VALID), .WTERM(WTERM),
        .A(A), .RW(RW), .ACCESS(ACCESS), .UDS(UDS), .LDS(LDS),
        .DOUT(DOUT), .DOE(DOE), .BUSY(BUSY), .ACK(ACK), .ERR(ERR), .RDATA(RDATA)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One transaction; iteration e runs just after edge e, where edge 0 accepts the request.
    // delay < 0 means no response; the response goes low right after edge (strobe edge + delay).
    task automatic applyStimulus(input logic we, input logic [22:0] addr, input logic [1:0] be,
                                 input logic [15:0] wdata, input int delay, input logic [15:0] rval,
                                 input logic hold, input int rst_at);
        int   s, ack_e, end_e;
        logic resp, err, act, strobe_win;
        REQ   = 1'b1;
        WE    = we;
        ADDR  = addr;
        BE    = be;
        WDATA = wdata;
        VALID = 1'b1;
        WTERM = 1'b1;
        D     = 16'($urandom);
        s     = we ? 3 : 2;
        resp  = (delay >= 0) && (delay + 2 <= TIMEOUT);
        if (be == 2'b00) begin
            ack_e = 1;
            err   = 1'b1;
        end else if (resp) begin
            ack_e = s + delay + 2;
            err   = 1'b0;
        end else begin
            ack_e = s + TIMEOUT;
            err   = 1'b1;
        end
        end_e = ack_e + RECOVERY;
        for (int e = 0; e <= end_e; e++) begin
            tick();
            act        = (be != 2'b00) && (e >= 2) && (e < ack_e);
            strobe_win = (be != 2'b00) && (e >= s) && (e < ack_e);
            checkOutput("busy", 32'(BUSY), 32'(e < end_e));
            checkOutput("ack", 32'(ACK), 32'(e == ack_e));
            checkOutput("access", 32'(ACCESS), 32'(!act));
            checkOutput("uds", 32'(UDS), 32'(!(strobe_win && be[1])));
            checkOutput("lds", 32'(LDS), 32'(!(strobe_win && be[0])));
            checkOutput("doe", 32'(DOE), 32'(we && act));
            if (we && act) checkOutput("dout", 32'(DOUT), 32'(wdata));
            if (be != 2'b00 && e >= 1 && e <= ack_e) begin
                checkOutput("addr", 32'(A), 32'(addr));
                checkOutput("rw", 32'(RW), 32'(!we));
            end
            if (e == ack_e) begin
                if (!we && !err) model_rdata = rval;
                checkOutput("err", 32'(ERR), 32'(err));
                checkOutput("rdata_ack", 32'(RDATA), 32'(model_rdata));
            end else if (e < ack_e) begin
                checkOutput("rdata_hold", 32'(RDATA), 32'(model_rdata));
            end
            if (e == rst_at) begin
                RST   = 1'b1;
                REQ   = 1'b0;
                VALID = 1'b1;
                WTERM = 1'b1;
                #1;
                checkOutput("rst_access", 32'(ACCESS), 32'd1);
                checkOutput("rst_uds", 32'(UDS), 32'd1);
                checkOutput("rst_lds", 32'(LDS), 32'd1);
                checkOutput("rst_doe", 32'(DOE), 32'd0);
                checkOutput("rst_ack", 32'(ACK), 32'd0);
                checkOutput("rst_busy", 32'(BUSY), 32'd0);
                RST         = 1'b0;
                model_rdata = '0;
                return;
            end
            // Inputs for the next edge; request fields are scrambled while busy to prove latching.
            if (e < end_e) begin
                REQ   = hold ? 1'b1 : 1'($urandom_range(0, 1));
                WE    = 1'($urandom);
                ADDR  = 23'($urandom);
                BE    = 2'($urandom);
                WDATA = 16'($urandom);
            end else begin
                REQ = hold;
            end
            if (resp && be != 2'b00 && e >= s + delay && e < ack_e) begin
                D = rval;
                if (we) begin
                    WTERM = 1'b0;
                    VALID = 1'($urandom);
                end else begin
                    VALID = 1'b0;
                    WTERM = 1'($urandom);
                end
            end else begin
                D = 16'($urandom);
                if (we) begin
                    WTERM = 1'b1;
                    VALID = 1'($urandom);
                end else begin
                    VALID = 1'b1;
                    WTERM = 1'($urandom);
                end
            end
        end
    endtask

    initial begin
        RST = 1'b1; REQ = 1'b0; WE = 1'b0; ADDR = '0; BE = '0; WDATA = '0;
        D = '0; VALID = 1'b1; WTERM = 1'b1;
        model_rdata = '0;
        #1;
        checkOutput("rst_a", 32'(A), 32'd0);
        checkOutput("rst_rw", 32'(RW), 32'd1);
        checkOutput("rst_access0", 32'(ACCESS), 32'd1);
        checkOutput("rst_uds0", 32'(UDS), 32'd1);
        checkOutput("rst_lds0", 32'(LDS), 32'd1);
        checkOutput("rst_dout", 32'(DOUT), 32'd0);
        checkOutput("rst_doe0", 32'(DOE), 32'd0);
        checkOutput("rst_busy0", 32'(BUSY), 32'd0);
        checkOutput("rst_ack0", 32'(ACK), 32'd0);
        checkOutput("rst_err", 32'(ERR), 32'd0);
        checkOutput("rst_rdata", 32'(RDATA), 32'd0);
        tick();
        tick();
        RST = 1'b0;

        $display("[TB] directed read, write, timeout, empty mask");
        applyStimulus(1'b0, 23'h123456, 2'b11, 16'h0000, 4, 16'hBEEF, 1'b0, -1);
        applyStimulus(1'b1, 23'h00ABCD, 2'b10, 16'hA55A, 1, 16'h0000, 1'b0, -1);
        applyStimulus(1'b0, 23'h000010, 2'b11, 16'h0000, -1, 16'h1234, 1'b0, -1);
        applyStimulus(1'b0, 23'h000020, 2'b00, 16'h0000, 0, 16'h5555, 1'b0, -1);
        applyStimulus(1'b1, 23'h000030, 2'b00, 16'h7777, 0, 16'h0000, 1'b0, -1);

        $display("[TB] minimum latency and timeout boundary");
        applyStimulus(1'b0, 23'h7FFFFF, 2'b01, 16'h0000, 0, 16'h0F0F, 1'b0, -1);
        applyStimulus(1'b1, 23'h400000, 2'b11, 16'hC3C3, 0, 16'h0000, 1'b0, -1);
        applyStimulus(1'b0, 23'h000040, 2'b11, 16'h0000, TIMEOUT - 2, 16'hCAFE, 1'b0, -1);
        applyStimulus(1'b0, 23'h000050, 2'b10, 16'h0000, TIMEOUT - 1, 16'hDEAD, 1'b0, -1);
        applyStimulus(1'b1, 23'h000060, 2'b01, 16'h3C3C, TIMEOUT - 2, 16'h0000, 1'b0, -1);
        applyStimulus(1'b1, 23'h000070, 2'b11, 16'h9999, TIMEOUT - 1, 16'h0000, 1'b0, -1);

        $display("[TB] reset during write wait, then fresh read");
        applyStimulus(1'b1, 23'h000080, 2'b11, 16'h1111, -1, 16'h0000, 1'b0, 5);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("post_rst_ack", 32'(ACK), 32'd0);
            checkOutput("post_rst_busy", 32'(BUSY), 32'd0);
        end
        applyStimulus(1'b0, 23'h000090, 2'b11, 16'h0000, 2, 16'h6789, 1'b0, -1);

        $display("[TB] back-to-back reads with REQ held");
        applyStimulus(1'b0, 23'h0000A0, 2'b11, 16'h0000, 1, 16'h0A0A, 1'b1, -1);
        applyStimulus(1'b0, 23'h0000A1, 2'b11, 16'h0000, 0, 16'h0B0B, 1'b1, -1);
        applyStimulus(1'b0, 23'h0000A2, 2'b11, 16'h0000, 3, 16'h0C0C, 1'b0, -1);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 24; i++) begin
            int dly;
            dly = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 9));
            applyStimulus(1'($urandom), 23'($urandom), 2'($urandom), 16'($urandom),
                          dly, 16'($urandom), 1'($urandom_range(0, 1)), -1);
        end
        REQ = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
